// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed-select or round-robin grant
// and a one-entry registered output stage that can drain and reload in the same cycle.
module stream_mux_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             vld_q, vld_d;

    logic             load_en;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    assign load_en = !vld_q || out_ready;

    // Round-robin picks the valid channel with the smallest distance past last_q,
    // so last_q itself ranks lowest; an out-of-range sel simply matches no channel.
    always_comb begin
        int best;
        int rank;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        best    = N_CH;
        rank    = 0;
        if (!mode) begin
            for (int i = 0; i < N_CH; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                rank = (i - int'(last_q) - 1 + N_CH) % N_CH;
                if (in_valid[i] && rank < best) begin
                    best    = rank;
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
            in_ready[i] = load_en && gnt_vld && (gnt_idx == SEL_W'(i));
        end
    end

    always_comb begin
        data_d = data_q;
        ch_d   = ch_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (load_en) begin
            if (gnt_vld) begin
                data_d = gnt_data;
                ch_d   = gnt_idx;
                vld_d  = 1'b1;
                last_d = gnt_idx;
            end else begin
                vld_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            ch_q   <= '0;
            vld_q  <= 1'b0;
            last_q <= SEL_W'(N_CH - 1);
        end else begin
            data_q <= data_d;
            ch_q   <= ch_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = vld_q;

endmodule
